// File: rtl/axis_inject_arbiter.sv
// Packet-granular round-robin merge of NUM_REQ AXI-Stream requesters onto one
// router injection port, delivered through a registered 2-entry skid buffer.
module axis_inject_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 4
) (
    input  logic                           clk_noc,
    input  logic                           rst_noc,
    input  logic [NUM_REQ-1:0]             s_tvalid,
    output logic [NUM_REQ-1:0]             s_tready,
    input  logic [NUM_REQ*TDATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_REQ-1:0]             s_tlast,
    input  logic [NUM_REQ*TID_WIDTH-1:0]   s_tid,
    input  logic [NUM_REQ*TDEST_WIDTH-1:0] s_tdest,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [TDATA_WIDTH-1:0]         m_tdata,
    output logic                           m_tlast,
    output logic [TID_WIDTH-1:0]           m_tid,
    output logic [TDEST_WIDTH-1:0]         m_tdest,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int ENT_W = TDATA_WIDTH + 1 + TID_WIDTH + TDEST_WIDTH;
    localparam logic [PTR_W:0] L_NUM = (PTR_W+1)'(NUM_REQ);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   w_rr_nxt;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   w_owner_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic               r_busy;

    logic               w_sel_found;
    logic [PTR_W-1:0]   w_sel_off;
    logic [PTR_W-1:0]   w_sel_idx;

    logic [1:0]         r_count;
    logic [1:0]         w_count_nxt;
    logic [ENT_W-1:0]   r_ent0;
    logic [ENT_W-1:0]   r_ent1;
    logic [ENT_W-1:0]   w_ent0_nxt;
    logic [ENT_W-1:0]   w_ent1_nxt;
    logic [ENT_W-1:0]   w_in_ent;
    logic               r_m_tvalid;

    logic               w_push;
    logic               w_pop;
    logic               w_in_last;

    // (base + off) mod NUM_REQ, valid for base, off < NUM_REQ
    function automatic logic [PTR_W-1:0] f_wrap_add(input logic [PTR_W-1:0] base,
                                                    input logic [PTR_W-1:0] off);
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= L_NUM) begin
            sum = sum - L_NUM;
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    // Round-robin pick: the lowest offset from rr_ptr with a valid request wins
    always_comb begin
        w_sel_off   = '0;
        w_sel_found = |s_tvalid;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sel_off = s_tvalid[f_wrap_add(r_rr_ptr, PTR_W'(k))] ? PTR_W'(k) : w_sel_off;
        end
        w_sel_idx = f_wrap_add(r_rr_ptr, w_sel_off);
    end

    // Owner's ready depends only on registered state, never on m_tready
    always_comb begin
        s_tready = '0;
        if ((r_state == ST_LOCKED) && (r_count != 2'd2)) begin
            s_tready[r_owner] = 1'b1;
        end else begin
            s_tready = '0;
        end
    end

    assign w_in_ent  = {s_tdata[32'(r_owner)*TDATA_WIDTH +: TDATA_WIDTH],
                        s_tlast[r_owner],
                        s_tid[32'(r_owner)*TID_WIDTH +: TID_WIDTH],
                        s_tdest[32'(r_owner)*TDEST_WIDTH +: TDEST_WIDTH]};
    assign w_in_last = s_tlast[r_owner];
    assign w_push    = (r_state == ST_LOCKED) & s_tvalid[r_owner] & s_tready[r_owner];
    assign w_pop     = (r_count != 2'd0) & m_tready;

    // Arbitration FSM next-state: grant held until the owner's tlast beat is taken
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_owner_nxt = r_owner;
        w_grant_nxt = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_found) begin
                    w_state_nxt = ST_LOCKED;
                    w_owner_nxt = w_sel_idx;
                    w_grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel_idx;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (w_push && w_in_last) begin
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = f_wrap_add(r_owner, {{(PTR_W-1){1'b0}}, 1'b1});
                    w_grant_nxt = '0;
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Arbitration state registers
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_owner  <= w_owner_nxt;
            r_grant  <= w_grant_nxt;
            r_busy   <= (w_state_nxt == ST_LOCKED);
        end
    end

    // Skid buffer next-state: entry 0 is always the head so m_* come straight from flops
    always_comb begin
        w_count_nxt = r_count;
        w_ent0_nxt  = r_ent0;
        w_ent1_nxt  = r_ent1;
        case (r_count)
            2'd0: begin
                if (w_push) begin
                    w_ent0_nxt  = w_in_ent;
                    w_count_nxt = 2'd1;
                end else begin
                    w_count_nxt = 2'd0;
                end
            end
            2'd1: begin
                if (w_push && w_pop) begin
                    w_ent0_nxt = w_in_ent;
                end else if (w_push) begin
                    w_ent1_nxt  = w_in_ent;
                    w_count_nxt = 2'd2;
                end else if (w_pop) begin
                    w_count_nxt = 2'd0;
                end else begin
                    w_count_nxt = 2'd1;
                end
            end
            2'd2: begin
                if (w_pop) begin
                    w_ent0_nxt  = r_ent1;
                    w_count_nxt = 2'd1;
                end else begin
                    w_count_nxt = 2'd2;
                end
            end
            default: begin
                w_count_nxt = 2'd0;
            end
        endcase
    end

    // Skid buffer registers; reset discards any buffered beats
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            r_count    <= 2'd0;
            r_ent0     <= '0;
            r_ent1     <= '0;
            r_m_tvalid <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_ent0     <= w_ent0_nxt;
            r_ent1     <= w_ent1_nxt;
            r_m_tvalid <= (w_count_nxt != 2'd0);
        end
    end

    assign m_tvalid = r_m_tvalid;
    assign m_tdata  = r_ent0[ENT_W-1 -: TDATA_WIDTH];
    assign m_tlast  = r_ent0[TID_WIDTH+TDEST_WIDTH];
    assign m_tid    = r_ent0[TDEST_WIDTH +: TID_WIDTH];
    assign m_tdest  = r_ent0[TDEST_WIDTH-1:0];
    assign grant    = r_grant;
    assign busy     = r_busy;

endmodule

// File: doc/axis_inject_arbiter.md
# axis_inject_arbiter

Packet-granular round-robin arbiter that shares one router injection port (`axis_in_*` of the router wrapper) among `NUM_REQ` AXI-Stream requesters on the NoC clock. A grant is held from a packet's first beat until its `tlast` beat is accepted, so packets from different requesters are never interleaved. The merged stream is delivered through a 2-entry skid buffer, which registers the path into the serializer shim at full throughput.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..16).
- `TDATA_WIDTH`, 32: data width; matches the router's `TDATA_WIDTH`.
- `TID_WIDTH`, 2: tid width, passed through unchanged.
- `TDEST_WIDTH`, 4: tdest width, passed through unchanged.

Ports:
- `clk_noc`  in  1  the single clock.
- `rst_noc`  in  1  reset, asynchronous and active-high.
- `s_tvalid`  in  NUM_REQ  per-requester valid.
- `s_tready`  out  NUM_REQ  per-requester ready.
- `s_tdata`  in  NUM_REQ*TDATA_WIDTH  packed data; requester i occupies bits `[i*TDATA_WIDTH +: TDATA_WIDTH]`.
- `s_tlast`  in  NUM_REQ  per-requester end-of-packet.
- `s_tid`  in  NUM_REQ*TID_WIDTH  packed tid.
- `s_tdest`  in  NUM_REQ*TDEST_WIDTH  packed tdest.
- `m_tvalid`, `m_tready`, `m_tdata`, `m_tlast`, `m_tid`, `m_tdest`  (`m_tready` in, the rest out)  merged stream to the router injection port.
- `grant`  out  NUM_REQ  one-hot current owner; all zero when idle.
- `busy`  out  1  high while in LOCKED.

## Operation
State machine `state ∈ {IDLE, LOCKED}`, with registers `rr_ptr` (clog2(NUM_REQ) bits) and `owner`.
- **IDLE**
  - `s_tready` is all zero.
  - If any `s_tvalid` is high, select the first valid index scanning `rr_ptr, rr_ptr+1, …`, wrapping modulo `NUM_REQ`.
  - Next cycle: `owner` takes the selected index, `grant` goes one-hot, and the state moves to LOCKED.
  - If no `s_tvalid` is high, stay in IDLE.
- **LOCKED**
  - `s_tready[owner] = (skid_count < 2)`. All other `s_tready` bits are 0.
  - A beat is accepted when `s_tvalid[owner] & s_tready[owner]`; it is written into the skid buffer.
  - When the accepted beat has `s_tlast = 1`: the next state is IDLE, `rr_ptr` becomes `(owner+1) mod NUM_REQ`, and `grant` clears.
- **Skid buffer**
  - 2-entry FIFO holding `{tdata, tlast, tid, tdest}`.
  - `m_tvalid = (skid_count != 0)`, and the `m_*` fields show the head entry.
  - Push and pop in the same cycle leave the count unchanged.
  - Full (count 2): the owner's `s_tready` is low.
  - Empty: `m_tvalid` is low.
- Requesters that are not granted are never acknowledged. Their `s_tvalid` may stay high indefinitely without loss.
- A requester whose `s_tvalid` drops mid-packet keeps the grant. The arbiter waits with no timeout.
- The arbiter is fair: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,…

## Timing
- Reset values:
  - `s_tready` = 0, `m_tvalid` = 0, `m_tdata`/`m_tlast`/`m_tid`/`m_tdest` = 0.
  - `grant` = 0, `busy` = 0.
  - `state` = IDLE, `rr_ptr` = 0, `skid_count` = 0.
- Arbitration costs one bubble cycle per packet. `s_tvalid` high in IDLE at cycle t gives `grant`/`s_tready` high at t+1.
- A beat accepted at cycle t is visible on `m_*` at t+1. `m_*` is purely registered; there is no combinational path from `s_*` to `m_*`.
- Throughput is 1 beat/cycle within a packet when `m_tready` is held high.
- `m_tready` reaches `s_tready` only through the registered `skid_count`, so there is no combinational ready chain.
- When a tlast beat is accepted at cycle t: IDLE at t+1, new grant at t+2. Beats already in the skid buffer continue to drain during re-arbitration.
- Asserting reset mid-operation immediately clears all state and discards buffered beats. Partial packets are lost, and upstream must restart them.

## Test plan
- **Single packet:** requester 2 sends a 3-beat packet (tdata 0xA0,0xA1,0xA2; tid 1, tdest 5; tlast on the 3rd beat) with `m_tready` = 1 → `grant` = 0b0100 one cycle after valid; `m` emits the 3 beats on consecutive cycles with fields intact; `busy` drops after tlast.
- **Fairness:** all 4 requesters continuously send 1-beat packets → output tid/source sequence is 0,1,2,3,0,1 with exactly one bubble between packets.
- **No interleaving:** requester 0 is mid-packet (2 of 4 beats sent) when requester 1 raises valid → `s_tready[1]` stays 0 until requester 0's tlast is accepted; requester 1 is granted 2 cycles later.
- **Backpressure:** `m_tready` = 0 for 5 cycles during a 6-beat packet → skid holds 2 beats, `s_tready[owner]` goes low, and no beat is dropped or duplicated after `m_tready` returns to 1.
- **Wrap-around:** `rr_ptr` = 3 after serving requester 2, with only requester 1 valid → requester 1 is granted; `rr_ptr` becomes 2 after its tlast.
- **Reset mid-packet:** assert `rst_noc` with 2 beats buffered → `m_tvalid`, `grant` and `s_tready` are 0 immediately; after release the first grant goes to the lowest valid index starting from 0.
